// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder.
// slave = adder side, master = producer/consumer side.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, carry_in, sub,
    output out_ready,
    input  in_ready, out_valid,
    input  c, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub,
    input  out_ready,
    output in_ready, out_valid,
    output c, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: segmented add/sub, one SEG-bit slice per stage, carry
// registered between slices; full-width c/carry_out/overflow/zero out.
// Ports: clk, rst (async, active-high), bus (pipelined_adder_if.slave):
//   in_valid/in_ready, a, b, carry_in, sub in; out_valid/out_ready,
//   c, carry_out, overflow, zero out.
// Option: define PIPELINED_ADDER_SAT_EN to clamp c on signed overflow.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic             out_v;
  logic             adv;
  logic [WIDTH-1:0] bp;

  // whole pipe moves together; stalls only when the output is held
  assign adv          = !out_v || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_v;
  assign bp           = bus.b ^ {WIDTH{bus.sub}};

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stg
    // IW: operand bits not yet consumed on entry to this stage
    // DW: result bits complete on exit from this stage
    localparam int IW = WIDTH - k * SEG;
    localparam int DW = (k + 1) * SEG;

    logic [IW-1:0]  a_i;
    logic [IW-1:0]  b_i;
    logic           ci;
    logic           vi;
    logic [SEG-1:0] seg_s;
    logic           seg_c;
    logic [DW-1:0]  s_d;

    assign {seg_c, seg_s} = {1'b0, a_i[SEG-1:0]}
                          + {1'b0, b_i[SEG-1:0]}
                          + {{SEG{1'b0}}, ci};

    if (k == 0) begin : g_src
      assign a_i = bus.a;
      assign b_i = bp;
      assign ci  = bus.carry_in;
      assign vi  = bus.in_valid;
      assign s_d = seg_s;
    end else begin : g_src
      assign a_i = g_stg[k-1].g_reg.a_q;
      assign b_i = g_stg[k-1].g_reg.b_q;
      assign ci  = g_stg[k-1].g_reg.c_q;
      assign vi  = g_stg[k-1].g_reg.v_q;
      assign s_d = {seg_s, g_stg[k-1].g_reg.s_q};
    end

    if (k < STAGES - 1) begin : g_reg
      // skew regs keep only the slices later stages still need;
      // s_q is the de-skew store of finished low slices
      logic [IW-SEG-1:0] a_q;
      logic [IW-SEG-1:0] b_q;
      logic [DW-1:0]     s_q;
      logic              c_q;
      logic              v_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
        end else if (adv) begin
          v_q <= vi;
          c_q <= seg_c;
          a_q <= a_i[IW-1:SEG];
          b_q <= b_i[IW-1:SEG];
          s_q <= s_d;
        end
      end
    end else begin : g_out
      logic             a_s;
      logic             b_s;
      logic             ovf;
      logic [WIDTH-1:0] c_d;
      logic [WIDTH-1:0] c_q;
      logic             co_q;
      logic             ov_q;
      logic             z_q;
      logic             v_q;

      // top slice still holds the sign bits of a and b'
      assign a_s = a_i[IW-1];
      assign b_s = b_i[IW-1];
      assign ovf = (a_s == b_s) && (s_d[WIDTH-1] != a_s);

`ifdef PIPELINED_ADDER_SAT_EN
      always_comb begin
        c_d = s_d;
        if (ovf) begin
          c_d = a_s ? {1'b1, {(WIDTH-1){1'b0}}}
                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign c_d = s_d;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q  <= 1'b0;
          c_q  <= '0;
          co_q <= 1'b0;
          ov_q <= 1'b0;
          z_q  <= 1'b0;
        end else if (adv) begin
          v_q  <= vi;
          c_q  <= c_d;
          co_q <= seg_c;
          ov_q <= ovf;
          z_q  <= (c_d == '0);
        end
      end

      assign out_v         = v_q;
      assign bus.c         = c_q;
      assign bus.carry_out = co_q;
      assign bus.overflow  = ov_q;
      assign bus.zero      = z_q & v_q;
    end
  end
endmodule
